// File: rtl/noc_arb_pkg.sv
// -----------------------------------------------------------------------------
// noc_arb_pkg
// Shared constants and helpers for the NoC output-port round-robin arbiter.
//   NPORT_DEF / FLIT_ID_W_DEF / LEN_W_DEF / HEADER_ID_DEF : default parameters
//   rr_pick(req, start, nport) : one-hot pick of the first requester found by
//                                scanning start, start+1, ... (mod nport)
// -----------------------------------------------------------------------------
package noc_arb_pkg;

    localparam int              NPORT_DEF     = 5;
    localparam int              FLIT_ID_W_DEF = 3;
    localparam int              LEN_W_DEF     = 12;
    localparam logic [2:0]      HEADER_ID_DEF = 3'b110;

    // Widest arbiter the shared pick function supports.
    localparam int MAX_PORTS = 32;
    localparam int MAX_IDX_W = $clog2(MAX_PORTS);

    // Scan the first nport bits of req starting at index start (start < nport)
    // and return the first set bit as a one-hot vector; zero if none is set.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input int                   start,
        input int                   nport
    );
        logic [MAX_PORTS-1:0] pick;
        logic                 found;
        int                   idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (k < nport) begin
                idx = start + k;
                if (idx >= nport) idx = idx - nport;
                if (!found && req[idx[MAX_IDX_W-1:0]]) begin
                    pick[idx[MAX_IDX_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_port_timer.sv
// -----------------------------------------------------------------------------
// arb_port_timer
// Per-port hold watchdog. Latches the packet length from every header flit
// and counts consecutive cycles of an active grant; timesup fires once the
// count reaches the latched length. A latched length of zero never fires.
//   clk, rst (async, active-low)
//   flit_id  : this port's flit id
//   length   : this port's packet length field
//   run      : port is granted, still requesting and not yet timed out
//   timesup  : hold budget exhausted
// -----------------------------------------------------------------------------
module arb_port_timer
    import noc_arb_pkg::*;
#(
    parameter int                   FLIT_ID_W = FLIT_ID_W_DEF,
    parameter int                   LEN_W     = LEN_W_DEF,
    parameter logic [FLIT_ID_W-1:0] HEADER_ID = HEADER_ID_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_ID_W-1:0] flit_id,
    input  logic [LEN_W-1:0]     length,
    input  logic                 run,
    output logic                 timesup
);

    logic [LEN_W-1:0] lim_q, lim_d;
    logic [LEN_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        lim_d   = lim_q;
        count_d = '0;
        if (flit_id == HEADER_ID) lim_d = length;
        if (run) count_d = (&count_q) ? count_q : count_q + 1'b1;
    end

    // >= rather than == so a shorter length arriving mid-grant still fires.
    assign timesup = (lim_q != '0) && (count_q >= lim_q);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lim_q   <= '0;
            count_q <= '0;
        end else begin
            lim_q   <= lim_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter
// Round-robin output arbiter for one router crossbar column. Grants at most
// one of NPORT inputs (registered one-hot); a holder keeps the grant while it
// requests and its watchdog has not expired.
//   clk, rst (async, active-low)
//   flit_id[NPORT*FLIT_ID_W] : packed per-port flit ids
//   length[NPORT*LEN_W]      : packed per-port packet lengths
//   req[NPORT]               : per-port requests
//   grant[NPORT]             : registered one-hot grant, zero when idle
//   grant_valid              : registered, high iff grant != 0
// Optional (macro ARB_TIMEOUT_STATUS_EN):
//   timeout_status[NPORT]    : sticky flag per port released by its watchdog
//   timeout_clr              : synchronous clear of all flags (set wins)
// -----------------------------------------------------------------------------
module noc_rr_arbiter
    import noc_arb_pkg::*;
#(
    parameter int                   NPORT     = NPORT_DEF,
    parameter int                   FLIT_ID_W = FLIT_ID_W_DEF,
    parameter int                   LEN_W     = LEN_W_DEF,
    parameter logic [FLIT_ID_W-1:0] HEADER_ID = HEADER_ID_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NPORT*FLIT_ID_W-1:0] flit_id,
    input  logic [NPORT*LEN_W-1:0]     length,
    input  logic [NPORT-1:0]           req,
    output logic [NPORT-1:0]           grant,
    output logic                       grant_valid
`ifdef ARB_TIMEOUT_STATUS_EN
    ,
    output logic [NPORT-1:0]           timeout_status,
    input  logic                       timeout_clr
`endif
);

    localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    logic [NPORT-1:0] grant_q, grant_d;
    logic             grant_valid_q;
    logic [IDX_W-1:0] last_q, last_d;
    logic [NPORT-1:0] run;
    logic [NPORT-1:0] timesup;

    for (genvar g = 0; g < NPORT; g++) begin : g_timer
        arb_port_timer #(
            .FLIT_ID_W (FLIT_ID_W),
            .LEN_W     (LEN_W),
            .HEADER_ID (HEADER_ID)
        ) u_timer (
            .clk     (clk),
            .rst     (rst),
            .flit_id (flit_id[g*FLIT_ID_W +: FLIT_ID_W]),
            .length  (length[g*LEN_W +: LEN_W]),
            .run     (run[g]),
            .timesup (timesup[g])
        );
    end

    // Non-zero only on the holder while it keeps its grant.
    assign run = grant_q & req & ~timesup;

    // While a port holds the grant, last already points at it (it was updated
    // on entry), so both IDLE and release scan from last+1. Masking the
    // current holder makes the release scan skip it.
    always_comb begin
        int start;
        grant_d = grant_q;
        last_d  = last_q;
        start   = (int'(last_q) >= NPORT - 1) ? 0 : int'(last_q) + 1;
        if (run == '0) begin
            grant_d = NPORT'(rr_pick(MAX_PORTS'(req & ~grant_q), start, NPORT));
        end
        for (int i = 0; i < NPORT; i++) begin
            if (grant_d[i]) last_d = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            last_q        <= IDX_W'(NPORT - 1);
        end else begin
            grant_q       <= grant_d;
            grant_valid_q <= |grant_d;
            last_q        <= last_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;

`ifdef ARB_TIMEOUT_STATUS_EN
    logic [NPORT-1:0] status_q;

    // A granted port with timesup is always released this cycle, so the
    // flag appears together with the dropped grant. Set is OR-ed after the
    // clear so it wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= '0;
        end else begin
            status_q <= (timeout_clr ? '0 : status_q) | (grant_q & timesup);
        end
    end

    assign timeout_status = status_q;
`endif

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_rr_arbiter
// Self-checking bench for noc_rr_arbiter: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural model
// (holder index, last index, per-port limit and hold counters).
// -----------------------------------------------------------------------------
module tb_noc_rr_arbiter;

    localparam int         N   = 5;
    localparam int         FW  = 3;
    localparam int         LW  = 12;
    localparam logic [2:0] HDR = 3'b110;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*FW-1:0]   flit_id;
    logic [N*LW-1:0]   length;
    logic [N-1:0]      req;
    logic [N-1:0]      grant;
    logic              grant_valid;
`ifdef ARB_TIMEOUT_STATUS_EN
    logic [N-1:0]      timeout_status;
    logic              timeout_clr;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int          m_holder;   // -1 when idle
    int          m_last;
    int          m_lim [N];
    int          m_cnt [N];
    logic [N-1:0] m_status;

    noc_rr_arbiter #(
        .NPORT     (N),
        .FLIT_ID_W (FW),
        .LEN_W     (LW),
        .HEADER_ID (HDR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flit_id        (flit_id),
        .length         (length),
        .req            (req),
        .grant          (grant),
        .grant_valid    (grant_valid)
`ifdef ARB_TIMEOUT_STATUS_EN
        ,
        .timeout_status (timeout_status),
        .timeout_clr    (timeout_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_holder >= 0) g[m_holder] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_holder = -1;
        m_last   = N - 1;
        m_status = '0;
        for (int i = 0; i < N; i++) begin
            m_lim[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [N-1:0] ts;
        int           nh;
        int           start;
        int           p;
        int           cmax;
        cmax = (1 << LW) - 1;
        for (int i = 0; i < N; i++) ts[i] = (m_lim[i] != 0) && (m_cnt[i] >= m_lim[i]);
        if (m_holder >= 0 && req[m_holder] && !ts[m_holder]) begin
            nh = m_holder;
        end else begin
            nh    = -1;
            start = (m_holder >= 0) ? m_holder : m_last;
            for (int k = 1; k <= N; k++) begin
                p = (start + k) % N;
                if (nh < 0 && p != m_holder && req[p]) nh = p;
            end
        end
`ifdef ARB_TIMEOUT_STATUS_EN
        if (timeout_clr) m_status = '0;
        if (m_holder >= 0 && ts[m_holder]) m_status[m_holder] = 1'b1;
`endif
        for (int i = 0; i < N; i++) begin
            if (i == m_holder && req[i] && !ts[i])
                m_cnt[i] = (m_cnt[i] < cmax) ? m_cnt[i] + 1 : cmax;
            else
                m_cnt[i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (flit_id[i*FW +: FW] == HDR) m_lim[i] = int'(length[i*LW +: LW]);
        end
        if (nh >= 0) m_last = nh;
        m_holder = nh;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("grant", 32'(grant), 32'(exp_grant()));
        check("grant_valid", 32'(grant_valid), 32'(m_holder >= 0));
`ifdef ARB_TIMEOUT_STATUS_EN
        check("timeout_status", 32'(timeout_status), 32'(m_status));
`endif
    endtask

    task automatic quiet();
        req     = '0;
        flit_id = '0;
        length  = '0;
`ifdef ARB_TIMEOUT_STATUS_EN
        timeout_clr = 1'b0;
`endif
    endtask

    task automatic set_hdr(input int p, input int len);
        flit_id[p*FW +: FW] = HDR;
        length[p*LW +: LW]  = LW'(len);
    endtask

    // Asynchronous reset pulse placed away from the clock edge; outputs
    // must clear before any further clock edge.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
`ifdef ARB_TIMEOUT_STATUS_EN
        check("rst_status", 32'(timeout_status), 32'h0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        quiet();
        model_reset();
        repeat (2) @(negedge clk);
        check("por_grant", 32'(grant), 32'h0);
        check("por_valid", 32'(grant_valid), 32'h0);
        rst = 1'b1;

        // Port 0 alone, length 4: 5 grant cycles, 1 idle, re-grant.
        req = 5'b00001;
        set_hdr(0, 4);
        tick();
        check("s1_first", 32'(grant), 32'b00001);
        flit_id = '0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("s1_hold", 32'(grant), 32'b00001);
        end
        tick();
        check("s1_idle", 32'(grant), 32'b00000);
        tick();
        check("s1_regrant", 32'(grant), 32'b00001);

        // Round robin with unlimited holds, wrapping past port 4.
        do_reset();
        quiet();
        req = 5'b10110;
        tick();
        check("s2_g1", 32'(grant), 32'b00010);
        req = 5'b10100;
        tick();
        check("s2_g2", 32'(grant), 32'b00100);
        req = 5'b10010;
        tick();
        check("s2_g4", 32'(grant), 32'b10000);
        req = 5'b00110;
        tick();
        check("s2_wrap", 32'(grant), 32'b00010);

        // Port 2 drops its request: port 3 is next, not port 1.
        do_reset();
        quiet();
        req = 5'b00100;
        tick();
        check("s3_hold2", 32'(grant), 32'b00100);
        req = 5'b01010;
        tick();
        check("s3_next", 32'(grant), 32'b01000);

        // Port 1 limit 10, shortened to 3 at count 6: release on next cycle.
        do_reset();
        quiet();
        req = 5'b00010;
        set_hdr(1, 10);
        tick();
        check("s4_grant", 32'(grant), 32'b00010);
        flit_id = '0;
        repeat (6) begin
            tick();
            check("s4_hold", 32'(grant), 32'b00010);
        end
        set_hdr(1, 3);
        req = 5'b11010;
        tick();
        check("s4_newlen", 32'(grant), 32'b00010);
        flit_id = '0;
        tick();
        check("s4_release", 32'(grant), 32'b01000);

        // Reset while port 3 holds, then port 0 wins among all requesters.
        do_reset();
        quiet();
        req = 5'b11111;
        tick();
        check("s5_port0", 32'(grant), 32'b00001);

`ifdef ARB_TIMEOUT_STATUS_EN
        // Sticky timeout flag, clear, and set-over-clear.
        do_reset();
        quiet();
        req = 5'b01000;
        set_hdr(3, 2);
        tick();
        check("s6_grant3", 32'(grant), 32'b01000);
        flit_id = '0;
        tick();
        tick();
        tick();
        check("s6_released", 32'(grant), 32'b00000);
        check("s6_status", 32'(timeout_status), 32'b01000);
        req = '0;
        tick();
        check("s6_sticky", 32'(timeout_status), 32'b01000);
        timeout_clr = 1'b1;
        tick();
        check("s6_clr", 32'(timeout_status), 32'b00000);
        timeout_clr = 1'b0;
        req = 5'b00001;
        set_hdr(0, 1);
        tick();
        flit_id = '0;
        tick();
        timeout_clr = 1'b1;
        tick();
        check("s6_setwins", 32'(timeout_status), 32'b00001);
        timeout_clr = 1'b0;
        req = '0;
        tick();
`endif

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        quiet();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0) req = N'($urandom_range(0, (1 << N) - 1));
            for (int p = 0; p < N; p++) begin
                flit_id[p*FW +: FW] = FW'($urandom_range(0, 7));
                length[p*LW +: LW]  = LW'($urandom_range(0, 6));
            end
`ifdef ARB_TIMEOUT_STATUS_EN
            timeout_clr = ($urandom_range(0, 7) == 0);
`endif
            if (c % 250 == 249) do_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/noc_rr_arbiter.md
Name: noc_rr_arbiter

Overview:
- Parametrised successor of the five-port NoC router output arbiter.
- Grants one of NPORT input ports at a time, one-hot, using rotating round-robin priority. Each port has a per-port watchdog timer whose limit is the packet length carried in that port's header flit.
- Sits in front of each router output crossbar column; grant drives the crossbar select.

Parameters:
- NPORT, 5, number of requesting input ports (>=2).
- FLIT_ID_W, 3, width of each port's flit_id field.
- LEN_W, 12, width of each port's length field and timer counter.
- HEADER_ID, 3'b110, flit_id value identifying a header flit.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- flit_id  input  NPORT*FLIT_ID_W  packed per-port flit id; port i occupies [i*FLIT_ID_W +: FLIT_ID_W].
- length  input  NPORT*LEN_W  packed per-port packet length, same packing.
- req  input  NPORT  per-port request.
- grant  output  NPORT  registered one-hot grant; all-zero means idle.
- grant_valid  output  1  registered; high iff grant != 0.
- timeout_status  output  NPORT  present only with ARB_TIMEOUT_STATUS_EN.
- timeout_clr  input  1  present only with ARB_TIMEOUT_STATUS_EN.

Behaviour:
- Reset (rst low, asynchronous):
  - grant=0, grant_valid=0.
  - All timer counts=0, all latched lengths=0.
  - last-holder pointer=NPORT-1, so port 0 has first priority.
- Length capture: every cycle in which flit_id[i]==HEADER_ID, lim[i] <= length[i], independent of grant.
- Timer i:
  - run[i] = grant[i] & req[i] & ~timesup[i].
  - count[i] <= run[i] ? count[i]+1 : 0. The counter saturates at all-ones.
  - timesup[i] = (lim[i]!=0) & (count[i] >= lim[i]). Use >= so a mid-grant length decrease still fires.
  - lim==0 means unlimited hold.
- State: IDLE (grant==0) or GRANT_i (grant[i]==1). The next grant is computed combinationally and registered, giving one cycle of latency from req to grant.
- IDLE: search ports last+1, last+2, ... (mod NPORT) and grant the first with req high. If none, stay IDLE.
- GRANT_i:
  - If req[i] & ~timesup[i], hold.
  - Otherwise search i+1 ... i+NPORT-1 (mod NPORT), excluding i. Grant the first requester, else go to IDLE.
  - With a continuous request and lim=L>0, port i holds exactly L+1 cycles. Timeout with no other requester goes to IDLE for one cycle, then port i is re-granted from count 0.
- last <= i whenever GRANT_i is left or entered. IDLE does not change last.
- Simultaneous req drop and timesup: treated as a single release.
- Header arriving on the granted port mid-grant: the new lim applies from the next cycle.
- Reset mid-grant: immediate return to reset values.

Optional Feature:
- Macro: ARB_TIMEOUT_STATUS_EN.
- When defined:
  - timeout_status[i] is set (sticky) in the cycle after grant[i] is released because of timesup[i].
  - Cleared by timeout_clr=1 (synchronous, all bits). Set wins over clear in the same cycle.
  - Reset value is 0.
- When undefined: timeout_status and timeout_clr are absent, and there is no extra logic.

Decomposition:
- Package noc_arb_pkg:
  - default constants: NPORT_DEF=5, FLIT_ID_W_DEF=3, LEN_W_DEF=12, HEADER_ID_DEF=3'b110.
  - function rr_pick(req, start) returning a one-hot vector.
- Sub-module arb_port_timer, instantiated NPORT times:
  - inputs: clk, rst, flit_id, length, run.
  - output: timesup.
  - contains lim and count.

Test Plan:
- Reset, then req=5'b00001 with a header on port 0 and length=4, held high -> grant=00001 from cycle 1, held 5 cycles, one IDLE cycle, then re-granted.
- req=5'b10110 all held, lim=0 on every port; release each holder in turn -> grant order 00010, 00100, 10000, 00010 (round robin, wrap past 4).
- Port 2 holding, req[2] dropped while req[1] and req[3] are high -> next grant=01000, not 00010.
- Port 1 granted with lim=10, count=6, then a header with length=3 arrives -> release on the next cycle (>= rule); ports 3 and 4 requesting -> grant=01000.
- rst pulsed low mid-grant asynchronously -> grant=0 and grant_valid=0 immediately; after release, port 0 wins among all requesters.
- With ARB_TIMEOUT_STATUS_EN: timeout on port 3 -> timeout_status=01000 sticky; timeout_clr=1 -> 00000; simultaneous set and clear on port 0 -> 00001.
